// File: rtl/spi_loader_pkg.sv
// Shared request codes, flash opcodes, FSM states and default sizes for spi_loader.
// SPI_FAST_READ_EN (set in spi_loader.sv) selects 0x0B plus dummy byte instead of 0x03.
package spi_loader_pkg;

  localparam logic [2:0] ACC_IDLE = 3'b000;
  localparam logic [2:0] ACC_BOOT = 3'b110;
  localparam logic [2:0] ACC_PAGE = 3'b111;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  localparam int unsigned BOOT_BITS_DEF = 8192;
  localparam int unsigned PAGE_BITS_DEF = 512;
  localparam logic [23:0] PAGE_BASE_DEF = 24'h000400;

  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned ADDR_BITS  = 24;
  localparam int unsigned DUMMY_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DONE
  } state_t;

  // States in which the flash is selected and the bit engine runs
  function automatic logic is_busy(input state_t s);
    return (s == ST_CMD) || (s == ST_ADDR) ||
           (s == ST_DUMMY) || (s == ST_DATA);
  endfunction

  function automatic logic [23:0] img_addr(
    input logic [2:0]  img,
    input logic        page,
    input logic [11:0] pos,
    input logic [23:0] base
  );
    logic [23:0] a;
    a = {2'b00, img, 19'd0};
    if (page) a = a + base + {6'd0, pos, 6'd0};
    return a;
  endfunction

endpackage

// File: rtl/spi_loader_shifter.sv
// Two-phase SPI mode-0 bit engine: phase A drives MOSI with CLK low,
// phase B raises CLK; MISO is captured on the edge that ends phase B.
module spi_loader_shifter (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic capture,
  input  logic tx,
  input  logic miso,
  output logic sclk,
  output logic mosi,
  output logic bit_end,
  output logic rx,
  output logic done
);

  logic ph_q;

  assign bit_end = run & ph_q;
  assign sclk    = ph_q;
  assign mosi    = run & tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= 1'b0;
      rx   <= 1'b0;
      done <= 1'b0;
    end else begin
      ph_q <= run & ~ph_q;
      done <= bit_end & capture;
      if (bit_end & capture) rx <= miso;
    end
  end

endmodule

// File: rtl/spi_loader.sv
// Copies a boot area or one page of a bubble image from W25Q32JV flash into the bit buffer.
// Define SPI_FAST_READ_EN to use Fast Read (0x0B) with 8 dummy clocks.
module spi_loader
  import spi_loader_pkg::*;
#(
  parameter int unsigned BOOT_BITS = BOOT_BITS_DEF,
  parameter int unsigned PAGE_BITS = PAGE_BITS_DEF,
  parameter logic [23:0] PAGE_BASE = PAGE_BASE_DEF
) (
  input  logic        MCLK,
  input  logic        nRESET,
  input  logic [2:0]  IMGNUM,
  input  logic [2:0]  ACCTYPE,
  input  logic [11:0] ABSPOS,
  output logic [14:0] OUTBUFWADDR,
  output logic        OUTBUFWDATA,
  output logic        OUTBUFWCLK,
  output logic        nCS,
  output logic        CLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        nWP,
  output logic        nHOLD
);

`ifdef SPI_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [7:0]  OPCODE     = FAST ? OP_FAST_READ : OP_READ;
  localparam logic [14:0] CMD_LAST   = 15'(CMD_BITS - 1);
  localparam logic [14:0] ADDR_LAST  = 15'(ADDR_BITS - 1);
  localparam logic [14:0] DUMMY_LAST = 15'(DUMMY_BITS - 1);
  localparam logic [14:0] BOOT_LAST  = 15'(BOOT_BITS - 1);
  localparam logic [14:0] PAGE_LAST  = 15'(PAGE_BITS - 1);

  state_t      state_q;
  state_t      state_d;
  logic [14:0] cnt_q;
  logic [14:0] waddr_q;
  logic [14:0] last_k;
  logic [31:0] sreg_q;
  logic        page_q;
  logic        ncs_q;
  logic        start;
  logic        run;
  logic        bit_end;
  logic        rx_bit;
  logic        wr_stb;
  logic        sclk;

  assign start  = (state_q == ST_IDLE) &&
                  ((ACCTYPE == ACC_BOOT) || (ACCTYPE == ACC_PAGE));
  assign run    = is_busy(state_q);
  assign last_k = page_q ? PAGE_LAST : BOOT_LAST;

  spi_loader_shifter u_shifter (
    .clk     (MCLK),
    .rst_n   (nRESET),
    .run     (run),
    .capture (state_q == ST_DATA),
    .tx      (sreg_q[31]),
    .miso    (MISO),
    .sclk    (sclk),
    .mosi    (MOSI),
    .bit_end (bit_end),
    .rx      (rx_bit),
    .done    (wr_stb)
  );

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_CMD;
      ST_CMD:   if (bit_end && cnt_q == CMD_LAST) state_d = ST_ADDR;
      ST_ADDR:
        if (bit_end && cnt_q == ADDR_LAST)
          state_d = FAST ? ST_DUMMY : ST_DATA;
      ST_DUMMY: if (bit_end && cnt_q == DUMMY_LAST) state_d = ST_DATA;
      ST_DATA:  if (bit_end && cnt_q == last_k) state_d = ST_DONE;
      // Re-arm only after the controller drops back to idle
      ST_DONE:  if (ACCTYPE == ACC_IDLE) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      cnt_q   <= '0;
      waddr_q <= '0;
      sreg_q  <= '0;
      page_q  <= 1'b0;
      ncs_q   <= 1'b1;
    end else begin
      ncs_q <= ~is_busy(state_d);
      if (state_d != state_q) cnt_q <= '0;
      else if (bit_end)       cnt_q <= cnt_q + 15'd1;
      // Address is fixed at request time, later input changes are ignored
      if (start) begin
        page_q <= (ACCTYPE == ACC_PAGE);
        sreg_q <= {OPCODE, img_addr(IMGNUM, ACCTYPE == ACC_PAGE,
                                    ABSPOS, PAGE_BASE)};
      end else if (bit_end) begin
        sreg_q <= {sreg_q[30:0], 1'b0};
      end
      if (bit_end && state_q == ST_DATA) waddr_q <= cnt_q;
    end
  end

  assign nCS         = ncs_q;
  assign CLK         = sclk;
  assign OUTBUFWADDR = waddr_q;
  assign OUTBUFWDATA = rx_bit;
  assign OUTBUFWCLK  = wr_stb;
  assign nWP         = 1'b1;
  assign nHOLD       = 1'b1;

endmodule

// File: tb/tb_spi_loader.sv
// Directed plus randomized bench for spi_loader with a behavioural W25Q32JV read model.
// Honours SPI_FAST_READ_EN the same way as the design.
module tb_spi_loader;

`ifdef SPI_FAST_READ_EN
  localparam int DUMMY = 8;
  localparam logic [7:0] EXP_CMD = 8'h0B;
`else
  localparam int DUMMY = 0;
  localparam logic [7:0] EXP_CMD = 8'h03;
`endif

  logic        MCLK = 1'b0;
  logic        nRESET;
  logic [2:0]  IMGNUM;
  logic [2:0]  ACCTYPE;
  logic [11:0] ABSPOS;
  logic [14:0] OUTBUFWADDR;
  logic        OUTBUFWDATA;
  logic        OUTBUFWCLK;
  logic        nCS;
  logic        CLK;
  logic        MOSI;
  logic        MISO = 1'b0;
  logic        nWP;
  logic        nHOLD;

  int n_assert = 0;
  int n_fail = 0;
  int unsigned seed;

  int          rcount = 0;
  int          falls = 0;
  logic [7:0]  f_cmd = '0;
  logic [23:0] f_addr = '0;
  int          fj;
  logic [7:0]  fb;

  int          strobes = 0;
  int          bad = 0;
  int          dbl = 0;
  logic        prev_stb = 1'b0;
  logic [23:0] exp_base = '0;
  logic [7:0]  mb;

  spi_loader dut (
    .MCLK        (MCLK),
    .nRESET      (nRESET),
    .IMGNUM      (IMGNUM),
    .ACCTYPE     (ACCTYPE),
    .ABSPOS      (ABSPOS),
    .OUTBUFWADDR (OUTBUFWADDR),
    .OUTBUFWDATA (OUTBUFWDATA),
    .OUTBUFWCLK  (OUTBUFWCLK),
    .nCS         (nCS),
    .CLK         (CLK),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .nWP         (nWP),
    .nHOLD       (nHOLD)
  );

  always #10 MCLK = ~MCLK;

  // Flash contents: a seeded hash of the byte address
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    logic [31:0] h;
    h = ({8'd0, a} ^ seed) * 32'h9E3779B1;
    return h[23:16];
  endfunction

  function automatic logic [23:0] model_addr(
    input logic [2:0] acc, input logic [2:0] img, input logic [11:0] pos);
    int unsigned a;
    a = img * 524288;
    if (acc == 3'b111) a = a + 1024 + pos * 64;
    return a[23:0];
  endfunction

  always @(negedge nCS) begin
    rcount = 0;
    f_cmd  = '0;
    f_addr = '0;
    falls++;
  end

  always @(posedge CLK) if (nCS === 1'b0) begin
    if (rcount < 8)       f_cmd  = {f_cmd[6:0], MOSI};
    else if (rcount < 32) f_addr = {f_addr[22:0], MOSI};
    rcount++;
  end

  always @(negedge CLK) if (nCS === 1'b0 && rcount >= 32 + DUMMY) begin
    fj   = rcount - 32 - DUMMY;
    fb   = fbyte(f_addr + 24'(fj / 8));
    MISO = fb[7 - fj % 8];
  end

  // Strobe k must carry address k and bit k of the expected byte stream
  always @(negedge MCLK) begin
    if (OUTBUFWCLK === 1'b1) begin
      if (prev_stb) dbl++;
      mb = fbyte(exp_base + 24'(strobes / 8));
      if (OUTBUFWADDR !== 15'(strobes) ||
          OUTBUFWDATA !== mb[7 - strobes % 8]) bad++;
      strobes++;
    end
    prev_stb = (OUTBUFWCLK === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ncs(input logic v, input int lim, input string tag);
    int i = 0;
    while (nCS !== v && i < lim) begin
      @(negedge MCLK);
      i++;
    end
    chk(tag, {31'd0, nCS}, {31'd0, v});
  endtask

  task automatic run_xfer(input logic [2:0] acc, input logic [2:0] img,
                          input logic [11:0] pos, input bit drop,
                          input string tag);
    int n;
    int f0;
    n = (acc == 3'b111) ? 512 : 8192;
    IMGNUM = img;
    ABSPOS = pos;
    ACCTYPE = 3'b000;
    repeat (2) @(negedge MCLK);
    exp_base = model_addr(acc, img, pos);
    strobes = 0;
    bad = 0;
    dbl = 0;
    f0 = falls;
    ACCTYPE = acc;
    wait_ncs(1'b0, 4, {tag, " start"});
    repeat (30) @(negedge MCLK);
    IMGNUM = 3'($urandom);
    ABSPOS = 12'($urandom);
    if (drop) ACCTYPE = 3'b000;
    wait_ncs(1'b1, 2 * (n + 40 + DUMMY) + 20, {tag, " end"});
    repeat (2) @(negedge MCLK);
    chk({tag, " cmd"}, {24'd0, f_cmd}, {24'd0, EXP_CMD});
    chk({tag, " addr"}, {8'd0, f_addr}, {8'd0, exp_base});
    chk({tag, " strobes"}, strobes, n);
    chk({tag, " bad bits"}, bad, 0);
    chk({tag, " double strobe"}, dbl, 0);
    chk({tag, " one select"}, falls, f0 + 1);
  endtask

  initial begin
    int f0;
    int s0;
    seed = $urandom;
    nRESET = 1'b0;
    ACCTYPE = 3'b000;
    IMGNUM = 3'd0;
    ABSPOS = 12'd0;
    repeat (3) @(negedge MCLK);
    chk("rst nCS", {31'd0, nCS}, 1);
    chk("rst CLK", {31'd0, CLK}, 0);
    chk("rst MOSI", {31'd0, MOSI}, 0);
    chk("rst WCLK", {31'd0, OUTBUFWCLK}, 0);
    chk("rst WADDR", {17'd0, OUTBUFWADDR}, 0);
    chk("rst WDATA", {31'd0, OUTBUFWDATA}, 0);
    chk("rst nWP", {31'd0, nWP}, 1);
    chk("rst nHOLD", {31'd0, nHOLD}, 1);
    nRESET = 1'b1;
    repeat (2) @(negedge MCLK);

    run_xfer(3'b110, 3'd0, 12'd0, 1'b0, "boot img0");
    run_xfer(3'b111, 3'd0, 12'd1018, 1'b0, "page 1018");

    f0 = falls;
    s0 = strobes;
    repeat (300) @(negedge MCLK);
    chk("held 111 no retrigger", falls, f0);
    chk("held 111 no strobes", strobes, s0);

    ACCTYPE = 3'b000;
    repeat (2) @(negedge MCLK);
    for (int c = 1; c <= 5; c++) begin
      ACCTYPE = 3'(c);
      repeat (5) @(negedge MCLK);
    end
    chk("codes 1-5 no select", falls, f0);
    chk("codes 1-5 no strobes", strobes, s0);
    chk("codes 1-5 nCS", {31'd0, nCS}, 1);

    for (int t = 0; t < 4; t++)
      run_xfer(3'b111, 3'($urandom), 12'($urandom), 1'($urandom), "rand page");
    run_xfer(3'b110, 3'($urandom), 12'($urandom), 1'b1, "rand boot");

    ACCTYPE = 3'b000;
    IMGNUM = 3'd7;
    ABSPOS = 12'd4095;
    repeat (2) @(negedge MCLK);
    exp_base = model_addr(3'b111, 3'd7, 12'd4095);
    strobes = 0;
    bad = 0;
    dbl = 0;
    f0 = falls;
    ACCTYPE = 3'b111;
    for (int i = 0; i < 2000 && strobes < 100; i++) @(negedge MCLK);
    chk("p4095 reached data", {31'd0, strobes >= 100}, 1);
    chk("p4095 addr", {8'd0, f_addr}, {8'd0, exp_base});
    chk("p4095 bad bits", bad, 0);
    #5;
    nRESET = 1'b0;
    ACCTYPE = 3'b000;
    #1;
    chk("midrst nCS", {31'd0, nCS}, 1);
    chk("midrst CLK", {31'd0, CLK}, 0);
    chk("midrst WCLK", {31'd0, OUTBUFWCLK}, 0);
    s0 = strobes;
    repeat (4) @(negedge MCLK);
    nRESET = 1'b1;
    repeat (100) @(negedge MCLK);
    chk("midrst no strobes", strobes, s0);
    chk("midrst no select", falls, f0 + 1);
    chk("midrst nCS idle", {31'd0, nCS}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
